// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary to packed BCD converter with counter Din/Load handoff.
// Optional build macro BIN2BCD_SAT_EN: saturate bcd_out/din_out to all nines on overflow.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf,
    output logic                  load_out,
    output logic [3:0]            din_out
);

    localparam int unsigned     W    = 4 * DIGITS;
    localparam int unsigned     CW   = $clog2(BIN_W + 1);
    localparam logic [CW-1:0]   LAST = CW'(BIN_W - 1);
`ifdef BIN2BCD_SAT_EN
    localparam logic [W-1:0]    NINES = {DIGITS{4'h9}};
`endif

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [W-1:0]     acc_q, acc_d;
    logic             sticky_q, sticky_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     bcd_q, bcd_d;
    logic             ovf_q, ovf_d;

    logic [W-1:0]     adj;
    logic [W-1:0]     acc_sh;
    logic [BIN_W-1:0] bin_sh;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            bin_q    <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
        end
    end

    // Per-digit add-3 correction; digits are independent, no inter-digit carry.
    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            else
                adj[4*i +: 4] = acc_q[4*i +: 4];
        end
    end

    assign acc_sh = {adj[W-2:0], bin_q[BIN_W-1]};
    assign bin_sh = bin_q << 1;
    assign accept = start && (state_q != S_SHIFT);

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_SHIFT: begin
                acc_d    = acc_sh;
                bin_d    = bin_sh;
                sticky_d = sticky_q | adj[W-1];
                cnt_d    = cnt_q + CW'(1);
                // Results are latched on the final shift so they are valid while done is high.
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    ovf_d   = sticky_d;
`ifdef BIN2BCD_SAT_EN
                    bcd_d   = sticky_d ? NINES : acc_sh;
`else
                    bcd_d   = acc_sh;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d  = S_SHIFT;
            bin_d    = bin_in;
            acc_d    = '0;
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_comb begin
        busy     = (state_q == S_SHIFT);
        done     = (state_q == S_DONE);
        load_out = (state_q == S_DONE);
    end

    assign bcd_out = bcd_q;
    assign din_out = bcd_q[3:0];
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: 3-digit and 2-digit instances driven in parallel, checked against an arithmetic model.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin_in;

    logic        busy0, done0, ovf0, load0;
    logic [11:0] bcd0;
    logic [3:0]  din0;
    logic        busy1, done1, ovf1, load1;
    logic [7:0]  bcd1;
    logic [3:0]  din1;

    logic [3:0]  cnt_m;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy0), .done(done0), .bcd_out(bcd0), .ovf(ovf0),
        .load_out(load0), .din_out(din0)
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy1), .done(done1), .bcd_out(bcd1), .ovf(ovf1),
        .load_out(load1), .din_out(din1)
    );

    // Downstream loadable BCD counter, modelled only as far as its load path.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt_m <= 4'd0;
        else if (load0) cnt_m <= din0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int unsigned v, input int unsigned d, input bit sat);
        int unsigned p = 1;
        int unsigned m;
        logic [11:0] r = '0;
        for (int unsigned i = 0; i < d; i++) p = p * 10;
        m = v % p;
        for (int unsigned i = 0; i < d; i++) begin
            r[4*i +: 4] = (sat && v >= p) ? 4'd9 : 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic check_result(input string tag, input int unsigned v);
        logic [11:0] e3, e2;
        e3 = ref_bcd(v, 3, SAT);
        e2 = ref_bcd(v, 2, SAT);
        chk({tag, "_done"},  32'(done0), 32'd1);
        chk({tag, "_load"},  32'(load0), 32'd1);
        chk({tag, "_busy"},  32'(busy0), 32'd0);
        chk({tag, "_bcd3"},  32'(bcd0),  32'(e3));
        chk({tag, "_din3"},  32'(din0),  32'(e3[3:0]));
        chk({tag, "_ovf3"},  32'(ovf0),  32'(v >= 1000));
        chk({tag, "_done2"}, 32'(done1), 32'd1);
        chk({tag, "_bcd2"},  32'(bcd1),  32'(e2[7:0]));
        chk({tag, "_din2"},  32'(din1),  32'(e2[3:0]));
        chk({tag, "_ovf2"},  32'(ovf1),  32'(v >= 100));
    endtask

    // Pulse start with v, then count cycles until done (bounded).
    task automatic run_conv(input logic [7:0] v, output int cyc);
        bin_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bin_in = 8'($urandom);
        cyc = 0;
        while (done0 !== 1'b1 && cyc < 30) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int pulses;
        logic [7:0] v;

        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = 8'd0;
        tick();
        tick();
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_load", 32'(load0), 32'd0);
        chk("rst_ovf",  32'(ovf0),  32'd0);
        chk("rst_bcd",  32'(bcd0),  32'd0);
        chk("rst_din",  32'(din0),  32'd0);
        chk("rst_ovf2", 32'(ovf1),  32'd0);
        rst_n = 1'b1;
        tick();

        // 255: busy exactly 8 cycles, done on the 9th.
        bin_in = 8'd255;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t255_busy", 32'(busy0), 32'd1);
            chk("t255_nodone", 32'(done0), 32'd0);
            tick();
        end
        check_result("t255", 255);
        tick();
        chk("t255_pulse_end", 32'(done0), 32'd0);
        chk("t255_hold", 32'(bcd0), 32'h255);
        chk("t255_cnt", 32'(cnt_m), 32'd5);

        // Back-to-back 0 then 99 with start held high.
        bin_in = 8'd0;
        start  = 1'b1;
        tick();
        bin_in = 8'd99;
        cyc = 0;
        while (done0 !== 1'b1 && cyc < 30) begin tick(); cyc++; end
        chk("b2b0_lat", 32'(cyc), 32'd8);
        check_result("b2b0", 0);
        tick();
        start = 1'b0;
        chk("b2b_noidle", 32'(busy0), 32'd1);
        cyc = 1;
        while (done0 !== 1'b1 && cyc < 30) begin tick(); cyc++; end
        chk("b2b_gap", 32'(cyc), 32'd9);
        check_result("b2b99", 99);
        tick();

        // Start during SHIFT is ignored.
        bin_in = 8'd37;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        bin_in = 8'd200;
        start  = 1'b1;
        tick();
        start = 1'b0;
        cyc = 3;
        while (done0 !== 1'b1 && cyc < 30) begin tick(); cyc++; end
        chk("ign_lat", 32'(cyc), 32'd8);
        check_result("ign37", 37);
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (done0 === 1'b1) pulses++;
        end
        chk("ign_no2nd", 32'(pulses), 32'd0);
        chk("ign_hold", 32'(bcd0), 32'h037);

        // Reset mid-conversion.
        bin_in = 8'd100;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy0), 32'd0);
        chk("mrst_done", 32'(done0), 32'd0);
        chk("mrst_bcd",  32'(bcd0),  32'd0);
        chk("mrst_din",  32'(din0),  32'd0);
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done0 === 1'b1) pulses++;
        end
        chk("mrst_nodone", 32'(pulses), 32'd0);
        run_conv(8'd128, cyc);
        chk("m128_lat", 32'(cyc), 32'd8);
        check_result("m128", 128);
        tick();
        chk("m128_cnt", 32'(cnt_m), 32'd8);

        // Counter handoff: load lands on the edge after the load_out pulse.
        run_conv(8'd7, cyc);
        chk("c7_lat", 32'(cyc), 32'd8);
        check_result("c7", 7);
        chk("c7_cnt_before", 32'(cnt_m), 32'd8);
        tick();
        chk("c7_cnt_after", 32'(cnt_m), 32'd7);

        // 2-digit overflow case.
        run_conv(8'd200, cyc);
        chk("o200_lat", 32'(cyc), 32'd8);
        check_result("o200", 200);
        tick();

        // Randomized values against the arithmetic model.
        for (int k = 0; k < 24; k++) begin
            v = 8'($urandom_range(0, 255));
            run_conv(v, cyc);
            chk("rnd_lat", 32'(cyc), 32'd8);
            check_result("rnd", 32'(v));
            tick();
            chk("rnd_cnt", 32'(cnt_m), 32'(ref_bcd(32'(v), 3, SAT) & 12'hf));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
